// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: a command/response port in front of AW/W/B and AR/R.
// A per-transaction watchdog aborts hung transfers and reports them as SLVERR with a timeout flag.
module axi_lite_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RA   = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_awvalid;
    logic              r_wvalid;
    logic              r_bready;
    logic              r_arvalid;
    logic              r_rready;
    logic [ADDR_W-1:0] r_awaddr;
    logic [ADDR_W-1:0] r_araddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [1:0]        r_rsp_resp;
    logic              r_rsp_timeout;

    logic w_busy;
    logic w_expire;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_finish;
    logic w_abort;
    logic w_aw_clear;
    logic w_w_clear;

    assign w_busy   = (r_state == S_WR) || (r_state == S_WB) ||
                      (r_state == S_RA) || (r_state == S_RD);
    assign w_expire = (TIMEOUT != 0) && w_busy && (r_cnt == CNT_LAST);

    // RREADY is raised combinationally on the AR handshake cycle so an early R beat is taken too.
    assign w_ar_hs  = (r_state == S_RA) && r_arvalid && ARREADY;
    assign w_b_hs   = r_bready && BVALID;
    assign w_r_hs   = (r_rready || w_ar_hs) && RVALID;
    assign w_finish = w_b_hs || w_r_hs;
    // A response arriving on the expiry cycle is still honoured; otherwise the watchdog wins.
    assign w_abort  = w_expire && !w_finish;

    assign w_aw_clear = !r_awvalid || AWREADY;
    assign w_w_clear  = !r_wvalid || WREADY;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_awaddr      <= '0;
            r_araddr      <= '0;
            r_wdata       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_busy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_finish || w_abort) begin
                r_state       <= S_DONE;
                r_rsp_valid   <= 1'b1;
                r_awvalid     <= 1'b0;
                r_wvalid      <= 1'b0;
                r_bready      <= 1'b0;
                r_arvalid     <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_timeout <= w_abort;
                r_rsp_resp    <= w_abort ? 2'b10 : (w_b_hs ? BRESP : RRESP);
                r_rsp_rdata   <= (w_r_hs && !w_abort) ? RDATA : '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            r_cnt <= '0;
                            if (cmd_write) begin
                                r_awaddr  <= cmd_addr;
                                r_wdata   <= cmd_wdata;
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_state   <= S_WR;
                            end else begin
                                r_araddr  <= cmd_addr;
                                r_arvalid <= 1'b1;
                                r_state   <= S_RA;
                            end
                        end
                    end
                    S_WR: begin
                        if (AWREADY) begin
                            r_awvalid <= 1'b0;
                        end
                        if (WREADY) begin
                            r_wvalid <= 1'b0;
                        end
                        if (w_aw_clear && w_w_clear) begin
                            r_bready <= 1'b1;
                            r_state  <= S_WB;
                        end
                    end
                    S_RA: begin
                        if (ARREADY) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_state   <= S_RD;
                        end
                    end
                    S_WB, S_RD: begin
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cmd_ready   = (r_state == S_IDLE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;
    assign AWADDR      = r_awaddr;
    assign AWVALID     = r_awvalid;
    assign WDATA       = r_wdata;
    assign WVALID      = r_wvalid;
    assign BREADY      = r_bready;
    assign ARADDR      = r_araddr;
    assign ARVALID     = r_arvalid;
    assign RREADY      = r_rready || w_ar_hs;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI-Lite slave with configurable delays, payload
// stability monitor, and a response scoreboard fed by the command driver.
module tb_axi_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY = 1'b0;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY = 1'b0;
    logic [1:0]  BRESP = 2'b00;
    logic        BVALID = 1'b0;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = 32'h0;
    logic [1:0]  RRESP = 2'b00;
    logic        RVALID = 1'b0;
    logic        RREADY;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   rsp_count = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    int       cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic     cfg_rand = 1'b0, cfg_ar_never = 1'b0, cfg_r_early = 1'b0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic        aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [31:0] got_awaddr = 0, got_wdata = 0, got_araddr = 0;
    logic        s_rst = 0, s_awv = 0, s_awr = 0, s_wv = 0, s_wr = 0, s_bv = 0, s_br = 0;
    logic        s_arv = 0, s_arr = 0, s_rv = 0, s_rr = 0;
    logic [31:0] s_awaddr = 0, s_wdata = 0, s_araddr = 0;

    function automatic int pick(input int d);
        return cfg_rand ? int'($urandom_range(0, 3)) : d;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (slv_mem.exists(a)) return slv_mem[a];
        return 32'h0;
    endfunction

    // Slave: reacts at negedge to handshakes seen at the preceding posedge, snapshots 2ns later.
    always begin
        @(negedge ACLK);
        if (!s_rst) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
            aw_wait = pick(cfg_aw_dly); w_wait = pick(cfg_w_dly); ar_wait = pick(cfg_ar_dly);
        end else begin
            if (!(rsp_valid === 1'b1 && rsp_timeout === 1'b1)) begin
                if (s_awv && !s_awr) begin
                    checks++;
                    if (AWVALID !== 1'b1 || AWADDR !== s_awaddr) begin
                        failures++;
                        $display("FAIL aw_stable got valid=%b addr=%h exp valid=1 addr=%h", AWVALID, AWADDR, s_awaddr);
                    end
                end
                if (s_wv && !s_wr) begin
                    checks++;
                    if (WVALID !== 1'b1 || WDATA !== s_wdata) begin
                        failures++;
                        $display("FAIL w_stable got valid=%b data=%h exp valid=1 data=%h", WVALID, WDATA, s_wdata);
                    end
                end
                if (s_arv && !s_arr) begin
                    checks++;
                    if (ARVALID !== 1'b1 || ARADDR !== s_araddr) begin
                        failures++;
                        $display("FAIL ar_stable got valid=%b addr=%h exp valid=1 addr=%h", ARVALID, ARADDR, s_araddr);
                    end
                end
            end
            if (s_awv && s_awr) begin aw_got = 1; got_awaddr = s_awaddr; end
            if (s_wv && s_wr) begin w_got = 1; got_wdata = s_wdata; end
            if (aw_got && w_got) begin
                slv_mem[got_awaddr] = got_wdata;
                aw_got = 0; w_got = 0; b_pend = 1; b_wait = pick(cfg_b_dly);
            end
            if (s_bv && s_br) BVALID = 0;
            if (s_arv && s_arr && !(s_rv && s_rr)) begin
                r_pend = 1; r_wait = pick(cfg_r_dly); got_araddr = s_araddr;
            end
            if (s_rv && s_rr) RVALID = 0;

            if (AWVALID === 1'b1) begin
                if (aw_wait == 0) AWREADY = 1; else begin aw_wait--; AWREADY = 0; end
            end else begin
                AWREADY = 0; aw_wait = pick(cfg_aw_dly);
            end
            if (WVALID === 1'b1) begin
                if (w_wait == 0) WREADY = 1; else begin w_wait--; WREADY = 0; end
            end else begin
                WREADY = 0; w_wait = pick(cfg_w_dly);
            end
            if (b_pend) begin
                if (b_wait == 0) begin BVALID = 1; BRESP = cfg_bresp; b_pend = 0; end
                else b_wait--;
            end
            if (ARVALID === 1'b1 && !cfg_ar_never) begin
                if (ar_wait == 0) begin
                    ARREADY = 1;
                    if (cfg_r_early) begin RVALID = 1; RDATA = rd(ARADDR); RRESP = cfg_rresp; end
                end else begin
                    ar_wait--; ARREADY = 0;
                end
            end else begin
                ARREADY = 0; ar_wait = pick(cfg_ar_dly);
            end
            if (r_pend) begin
                if (r_wait == 0) begin RVALID = 1; RDATA = rd(got_araddr); RRESP = cfg_rresp; r_pend = 0; end
                else r_wait--;
            end
        end
        #2;
        s_rst = ARESETn;
        s_awv = AWVALID; s_awr = AWREADY; s_awaddr = AWADDR;
        s_wv = WVALID; s_wr = WREADY; s_wdata = WDATA;
        s_bv = BVALID; s_br = BREADY;
        s_arv = ARVALID; s_arr = ARREADY; s_araddr = ARADDR;
        s_rv = RVALID; s_rr = RREADY;
    end

    // Response scoreboard
    always @(negedge ACLK) begin
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected got rdata=%h resp=%b timeout=%b", rsp_rdata, rsp_resp, rsp_timeout);
            end else begin
                mon_e = exp_q.pop_front();
                if ({rsp_rdata, rsp_resp, rsp_timeout} !== mon_e) begin
                    failures++;
                    $display("FAIL rsp_compare got rdata=%h resp=%b timeout=%b exp rdata=%h resp=%b timeout=%b",
                             rsp_rdata, rsp_resp, rsp_timeout, mon_e.rdata, mon_e.resp, mon_e.to);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic exp_to);
        exp_t e;
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_wait got=%b exp=1", cmd_ready);
            return;
        end
        if (exp_to) e = '{rdata: 32'h0, resp: 2'b10, to: 1'b1};
        else if (wr) e = '{rdata: 32'h0, resp: cfg_bresp, to: 1'b0};
        else e = '{rdata: (ref_mem.exists(addr) ? ref_mem[addr] : 32'h0), resp: cfg_rresp, to: 1'b0};
        if (wr && !exp_to) ref_mem[addr] = data;
        exp_q.push_back(e);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
        @(negedge ACLK);
        cmd_valid = 0; cmd_write = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        ARESETn = 0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin
            failures++;
            $display("FAIL reset_axi_ctrl got=%b exp=00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY});
        end
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rsp got v=%b to=%b resp=%b rdata=%h exp zero", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
        end
        checks++;
        if (AWADDR !== 32'h0 || ARADDR !== 32'h0 || WDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_payload got aw=%h ar=%h w=%h exp zero", AWADDR, ARADDR, WDATA);
        end
        ARESETn = 1;
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0;
        @(negedge ACLK);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        checks++;
        if (AWVALID !== 1'b1 || WVALID !== 1'b1 || AWADDR !== 32'h10 || WDATA !== 32'hDEADBEEF || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL wr_latency got awv=%b wv=%b aw=%h w=%h rdy=%b exp 1 1 00000010 deadbeef 0",
                     AWVALID, WVALID, AWADDR, WDATA, cmd_ready);
        end
        repeat (2) @(negedge ACLK);
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL wr_rsp_timing got rsp_valid=%b exp=1", rsp_valid);
        end
        @(negedge ACLK);
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL wr_rsp_pulse got rsp_valid=%b cmd_ready=%b exp 0 1", rsp_valid, cmd_ready);
        end
        wait_drain();
        checks++;
        if (rd(32'h10) !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_slave_mem got=%h exp=deadbeef", rd(32'h10));
        end
    endtask

    task automatic test_w_backpressure();
        cfg_aw_dly = 0; cfg_w_dly = 3; cfg_b_dly = 0;
        @(negedge ACLK);
        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        @(negedge ACLK);
        checks++;
        if (AWVALID !== 1'b0 || WVALID !== 1'b1) begin
            failures++;
            $display("FAIL aw_drops_alone got awv=%b wv=%b exp 0 1", AWVALID, WVALID);
        end
        @(negedge ACLK);
        @(negedge ACLK);
        checks++;
        if (WVALID !== 1'b1 || WDATA !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL w_held got wv=%b w=%h exp 1 deadbeef", WVALID, WDATA);
        end
        @(negedge ACLK);
        checks++;
        if (WVALID !== 1'b0) begin
            failures++;
            $display("FAIL w_drop got wv=%b exp 0", WVALID);
        end
        wait_drain();
        cfg_w_dly = 0;
        issue(1'b0, 32'h10, 32'h0, 1'b0);
        wait_drain();
    endtask

    task automatic test_read_early_r();
        issue(1'b1, 32'h20, 32'h12345678, 1'b0);
        wait_drain();
        cfg_r_early = 1;
        @(negedge ACLK);
        issue(1'b0, 32'h20, 32'h0, 1'b0);
        checks++;
        if (ARVALID !== 1'b1 || ARADDR !== 32'h20) begin
            failures++;
            $display("FAIL rd_latency got arv=%b ar=%h exp 1 00000020", ARVALID, ARADDR);
        end
        @(negedge ACLK);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678 || ARVALID !== 1'b0) begin
            failures++;
            $display("FAIL rd_early got v=%b rdata=%h arv=%b exp 1 12345678 0", rsp_valid, rsp_rdata, ARVALID);
        end
        wait_drain();
        cfg_r_early = 0;
    endtask

    task automatic test_timeout();
        int n_hi = 0;
        int i;
        cfg_ar_never = 1;
        @(negedge ACLK);
        issue(1'b0, 32'h40, 32'h0, 1'b1);
        for (i = 0; i < 60; i++) begin
            if (rsp_valid === 1'b1) break;
            if (ARVALID === 1'b1) n_hi++;
            @(negedge ACLK);
        end
        checks++;
        if (n_hi != 16 || i >= 60) begin
            failures++;
            $display("FAIL to_arvalid_cycles got=%0d exp=16", n_hi);
        end
        checks++;
        if (ARVALID !== 1'b0 || rsp_timeout !== 1'b1 || rsp_resp !== 2'b10) begin
            failures++;
            $display("FAIL to_abort got arv=%b to=%b resp=%b exp 0 1 10", ARVALID, rsp_timeout, rsp_resp);
        end
        @(negedge ACLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL to_cmd_ready got=%b exp=1", cmd_ready);
        end
        cfg_ar_never = 0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        cfg_b_dly = 6;
        @(negedge ACLK);
        issue(1'b1, 32'h30, 32'hA5A55A5A, 1'b0);
        @(negedge ACLK);
        checks++;
        if (BREADY !== 1'b1) begin
            failures++;
            $display("FAIL mid_in_wb got bready=%b exp=1", BREADY);
        end
        ARESETn = 0;
        @(negedge ACLK);
        checks++;
        if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout} !== 7'b0 ||
            AWADDR !== 32'h0 || WDATA !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_out got ctrl=%b aw=%h w=%h exp zero",
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout}, AWADDR, WDATA);
        end
        ARESETn = 1;
        void'(exp_q.pop_back());
        cfg_b_dly = 0;
        repeat (10) begin
            @(negedge ACLK);
            if (rsp_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_no_rsp got pulses=%0d exp=0", bad);
        end
        issue(1'b1, 32'h30, 32'h0BADF00D, 1'b0);
        wait_drain();
        checks++;
        if (rd(32'h30) !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL mid_after_write got=%h exp=0badf00d", rd(32'h30));
        end
    endtask

    task automatic test_random();
        int start;
        cfg_rand = 1; cfg_bresp = 2'b10; cfg_rresp = 2'b11;
        @(negedge ACLK);
        start = rsp_count;
        for (int k = 0; k < 200; k++) begin
            issue(1'($urandom_range(0, 1)), {27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom, 1'b0);
        end
        wait_drain();
        repeat (3) @(negedge ACLK);
        checks++;
        if (rsp_count - start != 200) begin
            failures++;
            $display("FAIL rand_rsp_count got=%0d exp=200", rsp_count - start);
        end
        cfg_rand = 0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_w_backpressure();
        test_read_early_r();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
